// File: rtl/s_type.sv
// RISC-V S-type store datapath: forms the byte address, passes the store data
// through, decodes byte-lane write enables, flags illegal widths and
// misaligned addresses, and keeps a running store count plus a sticky fault.
module s_type #(
  parameter logic [6:0] STORE_OPCODE = 7'b0100011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [11:0] imm,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] d_addr,
  output logic [31:0] d_data,
  output logic [3:0]  wr_en,
  output logic        illegal,
  output logic        misaligned,
  output logic [31:0] store_cnt,
  output logic        fault
);

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  logic        is_store;
  logic        store_ok;
  logic [2:0]  n_bytes;
  logic [31:0] imm_ext;
  logic [31:0] store_cnt_reg;
  logic [31:0] store_cnt_next;
  logic        fault_reg;
  logic        fault_next;

  // Sign-extend the 12-bit offset; the 32-bit add wraps naturally.
  assign imm_ext  = {{20{imm[11]}}, imm};
  assign d_addr   = in1 + imm_ext;
  assign d_data   = in2;
  assign is_store = (opcode == STORE_OPCODE);

  // Decode access width in bytes; zero width means no legal store this cycle.
  always_comb begin
    n_bytes    = 3'd0;
    store_ok   = 1'b0;
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          n_bytes  = 3'd1;
          store_ok = 1'b1;
        end
        F3_SH: begin
          n_bytes    = 3'd2;
          store_ok   = 1'b1;
          misaligned = d_addr[0];
        end
        F3_SW: begin
          n_bytes    = 3'd4;
          store_ok   = 1'b1;
          misaligned = (d_addr[1:0] != 2'b00);
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  // Each lane is enabled when it falls inside the access width starting at
  // byte 0; misalignment is advisory and never gates the lanes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wr_en[gi] = store_ok && (3'(gi) < n_bytes);
    end
  endgenerate

  // Next-state values for the counter and the sticky fault flag.
  always_comb begin
    store_cnt_next = store_cnt_reg;
    fault_next     = fault_reg;
    if (wr_en != 4'b0000)
      store_cnt_next = store_cnt_reg + 32'd1;
    if (illegal || misaligned)
      fault_next = 1'b1;
  end

  // Reset dominates any store or fault event on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      store_cnt_reg <= 32'd0;
      fault_reg     <= 1'b0;
    end else begin
      store_cnt_reg <= store_cnt_next;
      fault_reg     <= fault_next;
    end
  end

  assign store_cnt = store_cnt_reg;
  assign fault     = fault_reg;

endmodule

// File: tb/tb_s_type.sv
// Self-checking bench for s_type: directed cases followed by randomized
// transactions, compared against an arithmetic reference model.
module tb_s_type;

  localparam logic [6:0] ST_OP = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [11:0] imm;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [31:0] d_addr;
  logic [31:0] d_data;
  logic [3:0]  wr_en;
  logic        illegal;
  logic        misaligned;
  logic [31:0] store_cnt;
  logic        fault;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [31:0] m_cnt;
  logic        m_fault;

  s_type #(.STORE_OPCODE(ST_OP)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .imm(imm),
    .in1(in1), .in2(in2), .d_addr(d_addr), .d_data(d_data), .wr_en(wr_en),
    .illegal(illegal), .misaligned(misaligned), .store_cnt(store_cnt),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction: apply inputs, check combinational outputs, clock once,
  // then check the registered outputs against the model.
  task automatic txn(input string tag, input logic r, input logic [6:0] op,
                     input logic [2:0] f3, input logic [11:0] im,
                     input logic [31:0] a, input logic [31:0] b);
    int          off;
    int          width;
    logic [31:0] e_addr;
    logic [3:0]  e_wr;
    logic        e_ill;
    logic        e_mis;
    bit          st;
    off    = (im >= 12'd2048) ? int'(im) - 4096 : int'(im);
    e_addr = a + 32'(off);
    st     = (op == ST_OP);
    width  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    e_ill  = st && (width == 0);
    e_wr   = (st && width != 0) ? 4'((1 << width) - 1) : 4'd0;
    e_mis  = st && (width != 0) && ((e_addr % width) != 0);

    rst = r; opcode = op; funct3 = f3; imm = im; in1 = a; in2 = b;
    #1;
    check({tag, ".d_addr"}, d_addr, e_addr);
    check({tag, ".d_data"}, d_data, b);
    check({tag, ".wr_en"}, 32'(wr_en), 32'(e_wr));
    check({tag, ".illegal"}, 32'(illegal), 32'(e_ill));
    check({tag, ".misaligned"}, 32'(misaligned), 32'(e_mis));

    @(posedge clk);
    if (r) begin
      m_cnt   = 32'd0;
      m_fault = 1'b0;
    end else begin
      if (e_wr != 4'd0) m_cnt = m_cnt + 32'd1;
      if (e_ill || e_mis) m_fault = 1'b1;
    end
    #1;
    check({tag, ".store_cnt"}, store_cnt, m_cnt);
    check({tag, ".fault"}, 32'(fault), 32'(m_fault));
    $display("txn %-8s rst=%0b op=%b f3=%0d imm=%h in1=%h -> addr=%h wr=%b ill=%0b mis=%0b cnt=%0d fault=%0b",
             tag, r, op, f3, im, a, d_addr, wr_en, illegal, misaligned, store_cnt, fault);
  endtask

  initial begin
    m_cnt = 32'd0;
    m_fault = 1'b0;
    rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; imm = 12'd0; in1 = 32'd0; in2 = 32'd0;
    @(posedge clk);
    #1;
    check("reset.store_cnt", store_cnt, 32'd0);
    check("reset.fault", 32'(fault), 32'd0);
    rst = 1'b0;

    // Directed cases
    txn("sb",     1'b0, ST_OP, 3'd0, 12'hFFF, 32'h0000_1000, 32'hDEAD_BEEF);
    txn("sw_wrap",1'b0, ST_OP, 3'd2, 12'h004, 32'hFFFF_FFFC, 32'h1234_5678);
    txn("sw_2",   1'b0, ST_OP, 3'd2, 12'h004, 32'hFFFF_FFFC, 32'h8765_4321);
    txn("nonst",  1'b0, 7'd0,  3'd2, 12'h001, 32'h0000_0001, 32'h0);
    txn("nonst7", 1'b0, 7'd0,  3'd7, 12'h800, 32'h0000_0003, 32'h0);
    txn("sh_mis", 1'b0, ST_OP, 3'd1, 12'h000, 32'h0000_0001, 32'hCAFE_F00D);
    txn("rst_sw", 1'b1, ST_OP, 3'd2, 12'h000, 32'h0000_0100, 32'h5555_AAAA);
    txn("ill3",   1'b0, ST_OP, 3'd3, 12'h000, 32'h0000_0000, 32'h0);
    txn("rst2",   1'b1, 7'd0,  3'd0, 12'h000, 32'h0000_0000, 32'h0);
    txn("sw_mis", 1'b0, ST_OP, 3'd2, 12'h002, 32'h0000_0000, 32'h1);
    txn("rst3",   1'b1, 7'd0,  3'd0, 12'h000, 32'h0000_0000, 32'h0);
    txn("sh_ok",  1'b0, ST_OP, 3'd1, 12'hFFE, 32'h0000_0010, 32'h2);
    txn("sb_odd", 1'b0, ST_OP, 3'd0, 12'h7FF, 32'h0000_0000, 32'h3);

    // Randomized transactions
    for (int i = 0; i < 300; i++) begin
      logic [6:0] op;
      logic       r;
      op = ($urandom_range(0, 3) != 0) ? ST_OP : 7'($urandom);
      r  = ($urandom_range(0, 24) == 0);
      txn("rand", r, op, 3'($urandom_range(0, 7)), 12'($urandom),
          ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom,
          $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
